vga_scanout: RTL and testbench



---
 rtl/vga_scanout.sv | 178 +++++++++++++++++
 tb/tb_vga_scanout.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
//   Generates VGA horizontal/vertical timing from a free-running pixel clock
//   and pulls one 24-bit pixel word from an upstream stream for every visible
//   pixel once the stream has locked on to a frame start.
//
//   Handshake (colors_*): a word transfers in any cycle where colors_valid and
//   colors_ready are both high. colors_ready is high only in visible pixel
//   slots, and only once the block is running (or is entering RUN this very
//   cycle). The stream is never stalled for: a visible slot in RUN without a
//   valid word shows UNDERFLOW_RGB and is counted as an underflow.
//
// Ports
//   pixel_clock_clk    in   pixel clock (sole clock)
//   pixel_clock_reset  in   synchronous active-high reset
//   colors_valid       in   upstream word valid
//   colors_data[31:0]  in   [23:16] R, [15:8] G, [7:0] B, [31:24] ignored
//   colors_ready       out  word accepted this cycle (when valid)
//   vga_r/g/b[7:0]     out  registered pixel color
//   vga_hs, vga_vs     out  registered sync, polarity set by SYNC_POL
//   vga_blank_n        out  registered, high on visible pixels
//   frame_start        out  registered pulse, first pixel of a fed frame
//   underflow          out  sticky underflow flag
//   underflow_count    out  saturating count of underflow slots
//   dbg_state_o        out  FSM state (0 = WAIT, 1 = RUN)
// ---------------------------------------------------------------------------
module vga_scanout #(
    parameter int          H_ACTIVE      = 640,
    parameter int          H_FP          = 16,
    parameter int          H_SYNC        = 96,
    parameter int          H_BP          = 48,
    parameter int          V_ACTIVE      = 480,
    parameter int          V_FP          = 10,
    parameter int          V_SYNC        = 2,
    parameter int          V_BP          = 33,
    parameter bit          SYNC_POL      = 1'b0,
    parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
    input  logic        pixel_clock_clk,
    input  logic        pixel_clock_reset,
    input  logic        colors_valid,
    input  logic [31:0] colors_data,
    output logic        colors_ready,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        frame_start,
    output logic        underflow,
    output logic [15:0] underflow_count,
    output logic        dbg_state_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One extra value of headroom so sync-end bounds equal to the total fit.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS     = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_LO = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_HI = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS     = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_LO = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_HI = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    logic [23:0]   rgb_q;
    logic          hs_q;
    logic          vs_q;
    logic          blank_n_q;
    logic          frame_start_q;
    logic          underflow_q;
    logic [15:0]   underflow_count_q;

    logic          visible;
    logic          at_origin;
    logic          lock;
    logic          xfer;
    logic          ufl_slot;
    logic          hs_raw;
    logic          vs_raw;
    logic [23:0]   rgb_d;

    // The top byte of the pixel word carries no meaning here.
    logic          unused_hi;
    assign unused_hi = ^colors_data[31:24];

    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        state_d   = state_q;
        visible   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
        hs_raw    = (h_cnt_q >= H_SYNC_LO) && (h_cnt_q < H_SYNC_HI);
        vs_raw    = (v_cnt_q >= V_SYNC_LO) && (v_cnt_q < V_SYNC_HI);
        // Lock only when a valid word lines up with the very first pixel, so
        // the upstream stream and the raster agree on where a frame begins.
        lock      = (state_q == ST_WAIT) && at_origin && colors_valid;
        xfer      = colors_valid && colors_ready;
        ufl_slot  = visible && (state_q == ST_RUN) && !colors_valid;
        rgb_d     = 24'h000000;

        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end else begin
            h_cnt_d = h_cnt_q + 1'b1;
        end

        if (lock) begin
            state_d = ST_RUN;
        end

        if (xfer) begin
            rgb_d = colors_data[23:0];
        end else if (ufl_slot) begin
            rgb_d = UNDERFLOW_RGB;
        end
    end

    assign colors_ready = visible && ((state_q == ST_RUN) || lock);

    always_ff @(posedge pixel_clock_clk) begin
        if (pixel_clock_reset) begin
            state_q           <= ST_WAIT;
            h_cnt_q           <= '0;
            v_cnt_q           <= '0;
            rgb_q             <= 24'h000000;
            hs_q              <= ~SYNC_POL;
            vs_q              <= ~SYNC_POL;
            blank_n_q         <= 1'b0;
            frame_start_q     <= 1'b0;
            underflow_q       <= 1'b0;
            underflow_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            rgb_q         <= rgb_d;
            // SYNC_POL = 0 drives the pulse low, so invert the raw flag.
            hs_q          <= SYNC_POL ? hs_raw : ~hs_raw;
            vs_q          <= SYNC_POL ? vs_raw : ~vs_raw;
            blank_n_q     <= visible;
            frame_start_q <= at_origin && xfer;
            if (ufl_slot) begin
                underflow_q <= 1'b1;
                if (underflow_count_q != 16'hFFFF) begin
                    underflow_count_q <= underflow_count_q + 16'h0001;
                end
            end
        end
    end

    assign vga_r           = rgb_q[23:16];
    assign vga_g           = rgb_q[15:8];
    assign vga_b           = rgb_q[7:0];
    assign vga_hs          = hs_q;
    assign vga_vs          = vs_q;
    assign vga_blank_n     = blank_n_q;
    assign frame_start     = frame_start_q;
    assign underflow       = underflow_q;
    assign underflow_count = underflow_count_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_vga_scanout.sv
// ---------------------------------------------------------------------------
// tb_vga_scanout
//   Directed bench for vga_scanout. The main instance uses a tiny raster
//   (H 8/2/2/2, V 4/1/1/1 -> 14 x 7, 98 cycles per frame) so every cycle can
//   be checked against hand-derived timing. A second instance with a nearly
//   all-visible raster (H/V 200/1/1/1) drives the underflow counter into
//   saturation within a short run.
//   Cycle index k counts cycles after reset release; cycle k has
//   h = k % 14, v = (k / 14) % 7, and its registered outputs are visible
//   right after the clock edge that ends it.
// ---------------------------------------------------------------------------
module tb_vga_scanout;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FR = HT * VT;

  localparam int H2 = 203;
  localparam int V2 = 203;
  localparam int SAT_BUDGET = 80000;

  // -------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        colors_valid;
  logic [31:0] colors_data;
  logic        colors_ready;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, frame_start, underflow;
  logic [15:0] underflow_count;
  logic        dbg_state;

  logic        rst2;
  logic        valid2;
  logic [31:0] data2;
  logic        ready2;
  logic [7:0]  r2, g2, b2;
  logic        hs2, vs2, blank2, fs2, ufl2;
  logic [15:0] cnt2;
  logic        state2;

  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .UNDERFLOW_RGB(24'hFF00FF)
  ) dut (
    .pixel_clock_clk   (clk),
    .pixel_clock_reset (rst),
    .colors_valid      (colors_valid),
    .colors_data       (colors_data),
    .colors_ready      (colors_ready),
    .vga_r             (vga_r),
    .vga_g             (vga_g),
    .vga_b             (vga_b),
    .vga_hs            (vga_hs),
    .vga_vs            (vga_vs),
    .vga_blank_n       (vga_blank_n),
    .frame_start       (frame_start),
    .underflow         (underflow),
    .underflow_count   (underflow_count),
    .dbg_state_o       (dbg_state)
  );

  vga_scanout #(
    .H_ACTIVE(200), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(200), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .UNDERFLOW_RGB(24'hFF00FF)
  ) dut_sat (
    .pixel_clock_clk   (clk),
    .pixel_clock_reset (rst2),
    .colors_valid      (valid2),
    .colors_data       (data2),
    .colors_ready      (ready2),
    .vga_r             (r2),
    .vga_g             (g2),
    .vga_b             (b2),
    .vga_hs            (hs2),
    .vga_vs            (vs2),
    .vga_blank_n       (blank2),
    .frame_start       (fs2),
    .underflow         (ufl2),
    .underflow_count   (cnt2),
    .dbg_state_o       (state2)
  );

  // ---------------------------------------------------------------- scoreboard
  int tests = 0;
  int fails = 0;
  int k = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic vis(input int c);
    return ((c % HT) < 8) && (((c / HT) % VT) < 4);
  endfunction

  function automatic logic hs_act(input int c);
    return ((c % HT) >= 10) && ((c % HT) < 12);
  endfunction

  function automatic logic vs_act(input int c);
    return ((c / HT) % VT) == 5;
  endfunction

  function automatic logic vis2(input int c);
    return ((c % H2) < 200) && (((c / H2) % V2) < 200);
  endfunction

  // ------------------------------------------------------------------ drivers
  // Drives cycle k, checks colors_ready inside it, then checks the registered
  // outputs that cycle produced right after the closing edge.
  task automatic cyc(input logic v, input logic [31:0] d, input logic e_ready,
                     input logic [23:0] e_rgb, input logic e_fs);
    colors_valid = v;
    colors_data  = d;
    #1;
    chk($sformatf("ready@%0d", k), colors_ready, e_ready);
    @(posedge clk);
    #1;
    chk($sformatf("rgb@%0d", k), {vga_r, vga_g, vga_b}, e_rgb);
    chk($sformatf("blank_n@%0d", k), vga_blank_n, vis(k));
    chk($sformatf("hs@%0d", k), vga_hs, !hs_act(k));
    chk($sformatf("vs@%0d", k), vga_vs, !vs_act(k));
    chk($sformatf("fs@%0d", k), frame_start, e_fs);
    k++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 24'h000000);
    chk({tag, "_blank_n"}, vga_blank_n, 1'b0);
    chk({tag, "_hs"}, vga_hs, 1'b1);
    chk({tag, "_vs"}, vga_vs, 1'b1);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_underflow"}, underflow, 1'b0);
    chk({tag, "_count"}, underflow_count, 16'h0000);
    chk({tag, "_state"}, dbg_state, 1'b0);
  endtask

  // ----------------------------------------------------------------- sequence
  initial begin
    int w;
    int hs_low;
    int vs_low;
    int slots;
    int k2;
    logic slot;

    rst          = 1'b1;
    colors_valid = 1'b0;
    colors_data  = 32'h0;
    rst2         = 1'b1;
    valid2       = 1'b0;
    data2        = 32'h0;

    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    k   = 0;

    // Free-run with nothing valid: pure timing, no reads, no underflow.
    hs_low = 0;
    vs_low = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      cyc(1'b0, $urandom, 1'b0, 24'h000000, 1'b0);
      if (!vga_hs) hs_low++;
      if (!vga_vs) vs_low++;
    end
    chk("hs_low_cycles", hs_low, 28);
    chk("vs_low_cycles", vs_low, 28);
    chk("idle_underflow", underflow, 1'b0);
    chk("idle_count", underflow_count, 16'h0000);
    chk("idle_state", dbg_state, 1'b0);

    // Valid only in blanking while waiting: never accepted, still WAIT.
    for (int i = 0; i < FR; i++) begin
      cyc(!vis(k), $urandom, 1'b0, 24'h000000, 1'b0);
    end
    chk("blankvalid_state", dbg_state, 1'b0);
    chk("blankvalid_underflow", underflow, 1'b0);

    // Always valid from a frame start: lock, then one word per visible slot.
    w = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      if (vis(k)) begin
        cyc(1'b1, {8'($urandom), 24'(w)}, 1'b1, 24'(w), (k % FR) == 0);
        w++;
      end else begin
        cyc(1'b1, $urandom, 1'b0, 24'h000000, 1'b0);
      end
    end
    chk("stream_state", dbg_state, 1'b1);
    chk("stream_underflow", underflow, 1'b0);
    chk("stream_count", underflow_count, 16'h0000);

    // Drop valid for three visible slots at h = 2..4 of line 0.
    for (int i = 0; i < FR; i++) begin
      if (vis(k)) begin
        if (i >= 2 && i <= 4) begin
          cyc(1'b0, $urandom, 1'b1, 24'hFF00FF, 1'b0);
        end else begin
          cyc(1'b1, {8'($urandom), 24'(w)}, 1'b1, 24'(w), i == 0);
          w++;
        end
      end else begin
        cyc(1'b1, $urandom, 1'b0, 24'h000000, 1'b0);
      end
    end
    chk("drop_underflow", underflow, 1'b1);
    chk("drop_count", underflow_count, 16'h0003);

    // Mid-frame reset at v = 2, h = 5 while running.
    for (int i = 0; i < 2 * HT + 5; i++) begin
      if (vis(k)) begin
        cyc(1'b1, {8'($urandom), 24'(w)}, 1'b1, 24'(w), i == 0);
        w++;
      end else begin
        cyc(1'b1, $urandom, 1'b0, 24'h000000, 1'b0);
      end
    end
    rst          = 1'b1;
    colors_valid = 1'b1;
    colors_data  = $urandom;
    @(posedge clk);
    #1;
    chk_reset("midreset");
    rst = 1'b0;
    k   = 0;

    // First cycle after reset without valid, then valid all frame: no lock
    // until the next frame start.
    cyc(1'b0, $urandom, 1'b0, 24'h000000, 1'b0);
    for (int i = 1; i < FR; i++) begin
      cyc(1'b1, $urandom, 1'b0, 24'h000000, 1'b0);
    end
    chk("relock_wait_state", dbg_state, 1'b0);
    chk("relock_wait_underflow", underflow, 1'b0);
    w = 32'h00ABC0;
    for (int i = 0; i < 2 * HT; i++) begin
      if (vis(k)) begin
        cyc(1'b1, {8'($urandom), 24'(w)}, 1'b1, 24'(w), i == 0);
        w++;
      end else begin
        cyc(1'b1, $urandom, 1'b0, 24'h000000, 1'b0);
      end
    end
    chk("relock_state", dbg_state, 1'b1);

    // Saturation on the large raster: lock on the first pixel, then starve.
    @(posedge clk);
    #1;
    rst2   = 1'b0;
    valid2 = 1'b1;
    data2  = 32'h00123456;
    @(posedge clk);
    #1;
    chk("sat_lock_state", state2, 1'b1);
    chk("sat_first_rgb", {r2, g2, b2}, 24'h123456);
    valid2 = 1'b0;
    slots  = 0;
    k2     = 1;
    while (slots < 65537 && k2 < SAT_BUDGET) begin
      slot = vis2(k2);
      @(posedge clk);
      #1;
      if (slot) begin
        slots++;
        if (slots == 1) chk("sat_first_ufl_rgb", {r2, g2, b2}, 24'hFF00FF);
        if (slots == 1000) chk("sat_count_1000", cnt2, 16'd1000);
        if (slots == 65534) chk("sat_count_fffe", cnt2, 16'hFFFE);
        if (slots == 65535) chk("sat_count_ffff", cnt2, 16'hFFFF);
        if (slots == 65537) begin
          chk("sat_count_held", cnt2, 16'hFFFF);
          chk("sat_underflow", ufl2, 1'b1);
        end
      end
      k2++;
    end
    chk("sat_slots_within_budget", slots, 65537);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
